pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Combines three inputs:
  - the hazard-detector output (ID stage)
  - branch-taken (EXE stage)
  - SRAM handshake (MEM stage)
- Drives one consistent set of freeze/flush/bubble controls to PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Tracks stall and flush statistics and flags hazard livelock.

---
 rtl/pipeline_stall_controller_pkg.sv | 13 +
 rtl/pipeline_stall_controller_sat_counter.sv | 23 ++
 rtl/pipeline_stall_controller.sv | 115 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the memory-wait FSM encoding and the default counter width.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  localparam int DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
// Ports: clk, rst (async, active-high), inc, clr (sync), cnt.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// In: hazard, branch_taken, mem_req, mem_ready, clr_cnt. Out: freeze/flush/bubble, stats.
import pipeline_stall_controller_pkg::*;

module pipeline_stall_controller #(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int HAZ_MAX   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 clr_cnt,
  output logic                 freeze_pc,
  output logic                 flush_if,
  output logic                 bubble_id,
  output logic                 freeze_back,
  output logic                 mem_busy,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 livelock
);

  localparam logic [7:0] HZ_LIM = 8'(HAZ_MAX);

  state_t     state;
  state_t     state_nxt;
  logic       mem_stall;
  logic       haz_stall;
  logic [7:0] hz_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          mem_stall = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) mem_stall = 1'b1;
        else            state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // Outputs are gated by rst so they drop as soon as reset asserts,
  // not only once the state register has been cleared.
  always_comb begin
    freeze_pc   = 1'b0;
    flush_if    = 1'b0;
    bubble_id   = 1'b0;
    freeze_back = 1'b0;
    haz_stall   = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        freeze_pc   = 1'b1;
        freeze_back = 1'b1;
      end else if (branch_taken) begin
        flush_if  = 1'b1;
        bubble_id = 1'b1;
      end else if (hazard) begin
        freeze_pc = 1'b1;
        bubble_id = 1'b1;
        haz_stall = 1'b1;
      end
    end
  end

  assign mem_busy = (state == ST_MEM_WAIT);

  // livelock latches on the edge where the run length reaches HAZ_MAX+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_run   <= '0;
      livelock <= 1'b0;
    end else if (clr_cnt) begin
      hz_run   <= '0;
      livelock <= 1'b0;
    end else if (haz_stall) begin
      if (hz_run != 8'hff) hz_run <= hz_run + 8'd1;
      if (hz_run == HZ_LIM) livelock <= 1'b1;
    end else begin
      hz_run <= '0;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (freeze_pc | freeze_back),
    .clr (clr_cnt),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush (
    .clk (clk),
    .rst (rst),
    .inc (flush_if),
    .clr (clr_cnt),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller.
// Runs a 16-bit and a 4-bit counter instance side by side on the same stimulus.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard = 1'b0, branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0, clr_cnt = 1'b0;

  logic fpc, fif, bid, fbk, busy, ll;
  logic [15:0] scnt, fcnt;
  logic fpc4, fif4, bid4, fbk4, busy4, ll4;
  logic [3:0] scnt4, fcnt4;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.CNT_WIDTH(16), .HAZ_MAX(8)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .freeze_pc(fpc), .flush_if(fif), .bubble_id(bid), .freeze_back(fbk),
    .mem_busy(busy), .stall_cnt(scnt), .flush_cnt(fcnt), .livelock(ll)
  );

  pipeline_stall_controller #(.CNT_WIDTH(4), .HAZ_MAX(8)) dut4 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .freeze_pc(fpc4), .flush_if(fif4), .bubble_id(bid4), .freeze_back(fbk4),
    .mem_busy(busy4), .stall_cnt(scnt4), .flush_cnt(fcnt4), .livelock(ll4)
  );

  // in  = {hazard, branch_taken, mem_req, mem_ready, clr_cnt}
  // exp = {freeze_pc, flush_if, bubble_id, freeze_back, mem_busy}
  typedef struct packed {
    logic [4:0] in;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  int total = 0;
  int passed = 0;

  int m_stall, m_stall4, m_flush, m_run;
  logic m_ll;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h want %0h", n, a, e);
    else passed++;
  endtask

  function automatic vec_t v(input logic [4:0] i, input logic [4:0] e);
    vec_t r;
    r.in  = i;
    r.exp = e;
    return r;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_stall4 = 0; m_flush = 0; m_run = 0; m_ll = 1'b0;
  endtask

  // Called from posedge+2: drive, sample at posedge+7, advance model.
  task automatic step(input vec_t t);
    vec_t e;
    {hazard, branch_taken, mem_req, mem_ready, clr_cnt} = t.in;
    sb.push_back(t);
    #5;
    e = sb.pop_front();
    chk("ctl",   {27'd0, fpc, fif, bid, fbk, busy}, {27'd0, e.exp});
    chk("ctl4",  {27'd0, fpc4, fif4, bid4, fbk4, busy4}, {27'd0, e.exp});
    chk("stall", {16'd0, scnt}, m_stall);
    chk("flush", {16'd0, fcnt}, m_flush);
    chk("stall4", {28'd0, scnt4}, m_stall4);
    chk("live",  {31'd0, ll}, {31'd0, m_ll});
    if (e.in[0]) begin
      model_reset();
    end else begin
      if (e.exp[4] || e.exp[1]) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (e.exp[3] && m_flush < 65535) m_flush++;
      if (e.exp[4] && !e.exp[1]) begin
        if (m_run == 8) m_ll = 1'b1;
        m_run++;
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    // hazard stall, 3 cycles
    repeat (3) tbl.push_back(v(5'b10000, 5'b10100));
    tbl.push_back(v(5'b00000, 5'b00000));
    // branch wins over hazard
    tbl.push_back(v(5'b11000, 5'b01100));
    tbl.push_back(v(5'b00000, 5'b00000));
    // single-cycle memory access
    tbl.push_back(v(5'b00110, 5'b00000));
    // memory wait, ready after 4 stalled cycles
    tbl.push_back(v(5'b00100, 5'b10010));
    repeat (3) tbl.push_back(v(5'b00100, 5'b10011));
    tbl.push_back(v(5'b00110, 5'b00001));
    tbl.push_back(v(5'b00000, 5'b00000));
    // branch held through memory wait
    tbl.push_back(v(5'b01100, 5'b10010));
    repeat (2) tbl.push_back(v(5'b01100, 5'b10011));
    tbl.push_back(v(5'b01110, 5'b01101));
    tbl.push_back(v(5'b00000, 5'b00000));
    // new request during RELEASE is re-evaluated in RUN
    tbl.push_back(v(5'b00100, 5'b10010));
    tbl.push_back(v(5'b00110, 5'b00001));
    tbl.push_back(v(5'b00100, 5'b00000));
    tbl.push_back(v(5'b00100, 5'b10010));
    tbl.push_back(v(5'b00110, 5'b00001));
    tbl.push_back(v(5'b00000, 5'b00000));
    // livelock after 9 hazard cycles, then clear
    repeat (10) tbl.push_back(v(5'b10000, 5'b10100));
    tbl.push_back(v(5'b00000, 5'b00000));
    tbl.push_back(v(5'b00001, 5'b00000));
    tbl.push_back(v(5'b00000, 5'b00000));
    // long hazard run saturates the 4-bit counter
    repeat (20) tbl.push_back(v(5'b10000, 5'b10100));

    model_reset();
    @(posedge clk);
    #2;
    chk("rst_ctl", {27'd0, fpc, fif, bid, fbk, busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    chk("sat_stall16", {16'd0, scnt}, 32'd20);
    chk("sat_stall4", {28'd0, scnt4}, 32'd15);
    chk("sat_live", {31'd0, ll}, 32'd1);
    chk("sat_flush", {16'd0, fcnt}, 32'd0);

    // reset asserted between edges while in MEM_WAIT
    step(v(5'b00100, 5'b10010));
    step(v(5'b00100, 5'b10011));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ctl", {27'd0, fpc, fif, bid, fbk, busy}, 32'd0);
    chk("arst_cnt", {scnt, fcnt}, 32'd0);
    chk("arst_live", {30'd0, ll, ll4}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    // still RUN after reset: same request stalls from RUN, busy low
    step(v(5'b00100, 5'b10010));
    step(v(5'b00110, 5'b00001));
    step(v(5'b00000, 5'b00000));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
